// File: rtl/axi_id_compressor_pkg.sv
// Shared constants, sizing helpers and default wide/narrow AXI channel structs
// for the slave-side ID compressor.
package axi_id_compressor_pkg;

  localparam int unsigned DefNoMstPorts   = 4;
  localparam int unsigned DefIdWidth      = 4;
  localparam int unsigned DefSlvIdWidth   = DefIdWidth + $clog2(DefNoMstPorts);
  localparam int unsigned DefMstIdWidth   = 4;
  localparam int unsigned DefMaxUniqIds   = 4;
  localparam int unsigned DefMaxTxnsPerId = 4;
  localparam int unsigned AddrWidth       = 32;
  localparam int unsigned DataWidth       = 32;
  localparam int unsigned StrbWidth       = DataWidth / 8;

  function automatic int unsigned cnt_width(input int unsigned max_txns);
    return $clog2(max_txns + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  typedef logic [DefSlvIdWidth-1:0] slv_id_t;
  typedef logic [DefMstIdWidth-1:0] mst_id_t;
  typedef logic [AddrWidth-1:0]     addr_t;
  typedef logic [DataWidth-1:0]     data_t;
  typedef logic [StrbWidth-1:0]     strb_t;

  typedef struct packed {
    slv_id_t    id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [5:0] atop;
  } slv_aw_chan_t;

  typedef struct packed {
    mst_id_t    id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
    logic [5:0] atop;
  } mst_aw_chan_t;

  typedef struct packed {
    slv_id_t    id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } slv_ar_chan_t;

  typedef struct packed {
    mst_id_t    id;
    addr_t      addr;
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } mst_ar_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
  } w_chan_t;

  typedef struct packed {
    slv_id_t    id;
    logic [1:0] resp;
  } slv_b_chan_t;

  typedef struct packed {
    mst_id_t    id;
    logic [1:0] resp;
  } mst_b_chan_t;

  typedef struct packed {
    slv_id_t    id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
  } slv_r_chan_t;

  typedef struct packed {
    mst_id_t    id;
    data_t      data;
    logic [1:0] resp;
    logic       last;
  } mst_r_chan_t;

  typedef struct packed {
    slv_aw_chan_t aw;
    logic         aw_valid;
    w_chan_t      w;
    logic         w_valid;
    logic         b_ready;
    slv_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } slv_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    slv_b_chan_t b;
    logic        b_valid;
    slv_r_chan_t r;
    logic        r_valid;
  } slv_resp_t;

  typedef struct packed {
    mst_aw_chan_t aw;
    logic         aw_valid;
    w_chan_t      w;
    logic         w_valid;
    logic         b_ready;
    mst_ar_chan_t ar;
    logic         ar_valid;
    logic         r_ready;
  } mst_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        ar_ready;
    logic        w_ready;
    mst_b_chan_t b;
    logic        b_valid;
    mst_r_chan_t r;
    logic        r_valid;
  } mst_resp_t;

endpackage

// File: rtl/axi_id_compressor_table.sv
// One direction's remap table: wide ID per entry plus an outstanding counter;
// an entry is free exactly when its counter is zero.
module axi_id_compressor_table
  import axi_id_compressor_pkg::*;
#(
  parameter int unsigned IdWidth    = 6,
  parameter int unsigned Entries    = 4,
  parameter int unsigned MaxTxns    = 4,
  parameter int unsigned RspIdWidth = 4,
  parameter int unsigned NumChk     = 1,
  localparam int unsigned IdxWidth  = idx_width(Entries),
  localparam int unsigned CntWidth  = cnt_width(MaxTxns)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IdWidth-1:0]    lookup_id,
  output logic [IdxWidth-1:0]   lookup_idx,
  input  logic [IdxWidth-1:0]   chk_idx [NumChk],
  input  logic [IdWidth-1:0]    chk_id  [NumChk],
  output logic                  chk_ok  [NumChk],
  input  logic                  inc_en,
  input  logic [IdxWidth-1:0]   inc_idx,
  input  logic [IdWidth-1:0]    inc_id,
  input  logic                  rsp_valid,
  input  logic [RspIdWidth-1:0] rsp_mst_id,
  input  logic                  dec_en,
  output logic [IdWidth-1:0]    rsp_id
);

  localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxTxns);

  logic [IdWidth-1:0]  id_q  [Entries];
  logic [CntWidth-1:0] cnt_q [Entries];
  logic [Entries-1:0]  inc_sel, dec_sel;
  logic                hit, free_found, rsp_live;
  logic [IdxWidth-1:0] hit_idx, free_idx;

  // A live entry holding the ID wins; otherwise the lowest free entry is offered.
  always_comb begin
    hit        = 1'b0;
    hit_idx    = '0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < Entries; i++) begin
      if (cnt_q[i] != '0 && id_q[i] == lookup_id) begin
        hit     = 1'b1;
        hit_idx = IdxWidth'(i);
      end
      if (cnt_q[i] == '0 && !free_found) begin
        free_found = 1'b1;
        free_idx   = IdxWidth'(i);
      end
    end
    lookup_idx = hit ? hit_idx : free_idx;
  end

  // A candidate index is usable if free, or already owned by the same ID with headroom.
  always_comb begin
    for (int k = 0; k < NumChk; k++) begin
      chk_ok[k] = (cnt_q[chk_idx[k]] == '0) ||
                  (id_q[chk_idx[k]] == chk_id[k] && cnt_q[chk_idx[k]] < MaxCnt);
    end
  end

  always_comb begin
    inc_sel  = '0;
    dec_sel  = '0;
    rsp_id   = '0;
    rsp_live = 1'b0;
    for (int i = 0; i < Entries; i++) begin
      inc_sel[i] = inc_en && (inc_idx == IdxWidth'(i));
      if (rsp_mst_id == RspIdWidth'(i)) begin
        rsp_id     = id_q[i];
        rsp_live   = (cnt_q[i] != '0);
        dec_sel[i] = dec_en;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Entries; i++) begin
        id_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < Entries; i++) begin
        if (inc_sel[i] && !dec_sel[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
          if (cnt_q[i] == '0) id_q[i] <= inc_id;
        end else if (dec_sel[i] && !inc_sel[i] && cnt_q[i] != '0) begin
          cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

  rsp_known: assert property (@(posedge clk) disable iff (!rst_n) rsp_valid |-> rsp_live);

endmodule

// File: rtl/axi_id_compressor.sv
// Compresses crossbar-widened AXI IDs onto a small pool of narrow IDs and
// restores the original IDs on R/B, keeping per-ID ordering intact.
module axi_id_compressor
  import axi_id_compressor_pkg::*;
#(
  parameter int unsigned NoMstPorts   = DefNoMstPorts,
  parameter int unsigned IdWidth      = DefIdWidth,
  parameter int unsigned MstIdWidth   = DefMstIdWidth,
  parameter int unsigned MaxUniqIds   = DefMaxUniqIds,
  parameter int unsigned MaxTxnsPerId = DefMaxTxnsPerId,
  parameter type slv_req_t  = axi_id_compressor_pkg::slv_req_t,
  parameter type slv_resp_t = axi_id_compressor_pkg::slv_resp_t,
  parameter type mst_req_t  = axi_id_compressor_pkg::mst_req_t,
  parameter type mst_resp_t = axi_id_compressor_pkg::mst_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  slv_req_t  slv_req_i,
  output slv_resp_t slv_resp_o,
  output mst_req_t  mst_req_o,
  input  mst_resp_t mst_resp_i
);

  localparam int unsigned SlvIdWidth = IdWidth + $clog2(NoMstPorts);
  localparam int unsigned IdxWidth   = idx_width(MaxUniqIds);

  logic [IdxWidth-1:0]   rd_idx, wr_idx, rd_inc_idx;
  logic [IdxWidth-1:0]   rd_chk_idx [2];
  logic [SlvIdWidth-1:0] rd_chk_id  [2];
  logic                  rd_chk_ok  [2];
  logic [IdxWidth-1:0]   wr_chk_idx [1];
  logic [SlvIdWidth-1:0] wr_chk_id  [1];
  logic                  wr_chk_ok  [1];
  logic [SlvIdWidth-1:0] rd_rsp_id, wr_rsp_id, rd_inc_id;
  logic                  atop_r, ar_ok, aw_ok, ar_hs, aw_hs, r_done, b_done;

  assign atop_r        = slv_req_i.aw.atop[5];
  assign rd_chk_idx[0] = rd_idx;
  assign rd_chk_id[0]  = slv_req_i.ar.id;
  assign rd_chk_idx[1] = wr_idx;
  assign rd_chk_id[1]  = slv_req_i.aw.id;
  assign wr_chk_idx[0] = wr_idx;
  assign wr_chk_id[0]  = slv_req_i.aw.id;

  // A presented R-returning ATOP holds AR off so only one source claims read entries per cycle.
  assign ar_ok  = rd_chk_ok[0] & ~(slv_req_i.aw_valid & atop_r);
  assign aw_ok  = wr_chk_ok[0] & (~atop_r | rd_chk_ok[1]);
  assign ar_hs  = slv_req_i.ar_valid & ar_ok & mst_resp_i.ar_ready;
  assign aw_hs  = slv_req_i.aw_valid & aw_ok & mst_resp_i.aw_ready;
  assign r_done = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
  assign b_done = mst_resp_i.b_valid & slv_req_i.b_ready;

  assign rd_inc_idx = ar_hs ? rd_idx : wr_idx;
  assign rd_inc_id  = ar_hs ? slv_req_i.ar.id : slv_req_i.aw.id;

  axi_id_compressor_table #(
    .IdWidth(SlvIdWidth), .Entries(MaxUniqIds), .MaxTxns(MaxTxnsPerId),
    .RspIdWidth(MstIdWidth), .NumChk(2)
  ) i_rd_table (
    .clk(clk_i), .rst_n(rst_ni),
    .lookup_id(slv_req_i.ar.id), .lookup_idx(rd_idx),
    .chk_idx(rd_chk_idx), .chk_id(rd_chk_id), .chk_ok(rd_chk_ok),
    .inc_en(ar_hs | (aw_hs & atop_r)), .inc_idx(rd_inc_idx), .inc_id(rd_inc_id),
    .rsp_valid(mst_resp_i.r_valid), .rsp_mst_id(mst_resp_i.r.id),
    .dec_en(r_done), .rsp_id(rd_rsp_id)
  );

  axi_id_compressor_table #(
    .IdWidth(SlvIdWidth), .Entries(MaxUniqIds), .MaxTxns(MaxTxnsPerId),
    .RspIdWidth(MstIdWidth), .NumChk(1)
  ) i_wr_table (
    .clk(clk_i), .rst_n(rst_ni),
    .lookup_id(slv_req_i.aw.id), .lookup_idx(wr_idx),
    .chk_idx(wr_chk_idx), .chk_id(wr_chk_id), .chk_ok(wr_chk_ok),
    .inc_en(aw_hs), .inc_idx(wr_idx), .inc_id(slv_req_i.aw.id),
    .rsp_valid(mst_resp_i.b_valid), .rsp_mst_id(mst_resp_i.b.id),
    .dec_en(b_done), .rsp_id(wr_rsp_id)
  );

  always_comb begin
    mst_req_o  = '0;
    slv_resp_o = '0;

    mst_req_o.aw.id    = MstIdWidth'(wr_idx);
    mst_req_o.aw.addr  = slv_req_i.aw.addr;
    mst_req_o.aw.len   = slv_req_i.aw.len;
    mst_req_o.aw.size  = slv_req_i.aw.size;
    mst_req_o.aw.burst = slv_req_i.aw.burst;
    mst_req_o.aw.atop  = slv_req_i.aw.atop;
    mst_req_o.aw_valid = slv_req_i.aw_valid & aw_ok;
    mst_req_o.w        = slv_req_i.w;
    mst_req_o.w_valid  = slv_req_i.w_valid;
    mst_req_o.b_ready  = slv_req_i.b_ready;
    mst_req_o.ar.id    = MstIdWidth'(rd_idx);
    mst_req_o.ar.addr  = slv_req_i.ar.addr;
    mst_req_o.ar.len   = slv_req_i.ar.len;
    mst_req_o.ar.size  = slv_req_i.ar.size;
    mst_req_o.ar.burst = slv_req_i.ar.burst;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ar_ok;
    mst_req_o.r_ready  = slv_req_i.r_ready;

    slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_ok;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_ok;
    slv_resp_o.w_ready  = mst_resp_i.w_ready;
    slv_resp_o.b.id     = wr_rsp_id;
    slv_resp_o.b.resp   = mst_resp_i.b.resp;
    slv_resp_o.b_valid  = mst_resp_i.b_valid;
    slv_resp_o.r.id     = rd_rsp_id;
    slv_resp_o.r.data   = mst_resp_i.r.data;
    slv_resp_o.r.resp   = mst_resp_i.r.resp;
    slv_resp_o.r.last   = mst_resp_i.r.last;
    slv_resp_o.r_valid  = mst_resp_i.r_valid;
  end

endmodule

// File: tb/tb_axi_id_compressor.sv
// Directed bench for axi_id_compressor: a table-level reference model checked
// every cycle, plus literal expectations at the key points of each scenario.
module tb_axi_id_compressor;
  import axi_id_compressor_pkg::*;

  localparam int Entries = DefMaxUniqIds;
  localparam int MaxTxns = DefMaxTxnsPerId;

  logic      clk = 1'b0;
  logic      rst_n;
  slv_req_t  slv_req;
  slv_resp_t slv_resp;
  mst_req_t  mst_req;
  mst_resp_t mst_resp;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference state: index 0 = read direction, 1 = write direction.
  int           m_cnt [2][Entries];
  logic [5:0]   m_id  [2][Entries];
  bit           p_ar, p_aw, p_atop, p_r, p_b;
  int           p_ar_i, p_aw_i, p_r_i, p_b_i;
  logic [5:0]   p_ar_id, p_aw_id;

  axi_id_compressor dut (
    .clk_i(clk), .rst_ni(rst_n),
    .slv_req_i(slv_req), .slv_resp_o(slv_resp),
    .mst_req_o(mst_req), .mst_resp_i(mst_resp)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: handshake never came, expected within 50 cycles", name);
  endtask

  function automatic void mdl_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < Entries; i++) begin
        m_cnt[d][i] = 0;
        m_id[d][i]  = '0;
      end
  endfunction

  function automatic void mdl_pick(input int d, input logic [5:0] id, output int idx, output bit ok);
    idx = -1;
    for (int i = 0; i < Entries; i++)
      if (m_cnt[d][i] > 0 && m_id[d][i] == id) idx = i;
    if (idx >= 0) begin
      ok = (m_cnt[d][idx] < MaxTxns);
    end else begin
      ok = 1'b0;
      idx = 0;
      for (int i = Entries - 1; i >= 0; i--)
        if (m_cnt[d][i] == 0) begin
          idx = i;
          ok  = 1'b1;
        end
    end
  endfunction

  function automatic void mdl_inc(input int d, input int i, input logic [5:0] id);
    if (m_cnt[d][i] == 0) m_id[d][i] = id;
    m_cnt[d][i]++;
  endfunction

  function automatic void mdl_dec(input int d, input int i);
    if (i < Entries && m_cnt[d][i] > 0) m_cnt[d][i]--;
  endfunction

  always @(negedge clk) begin
    int  ar_i, aw_i;
    bit  ar_can, aw_can, rd_ok, atop_pend;
    p_ar = 0; p_aw = 0; p_r = 0; p_b = 0;
    if (!rst_n) begin
      mdl_clear();
    end else begin
      mdl_pick(0, slv_req.ar.id, ar_i, ar_can);
      mdl_pick(1, slv_req.aw.id, aw_i, aw_can);
      atop_pend = slv_req.aw_valid && slv_req.aw.atop[5];
      rd_ok = (m_cnt[0][aw_i] == 0) || (m_id[0][aw_i] == slv_req.aw.id && m_cnt[0][aw_i] < MaxTxns);
      ar_can = ar_can && !atop_pend;
      aw_can = aw_can && (!slv_req.aw.atop[5] || rd_ok);

      check_output("ar_valid", mst_req.ar_valid, slv_req.ar_valid && ar_can);
      check_output("ar_ready", slv_resp.ar_ready, mst_resp.ar_ready && ar_can);
      if (slv_req.ar_valid && ar_can) begin
        check_output("ar_id", mst_req.ar.id, ar_i);
        check_output("ar_addr", mst_req.ar.addr, slv_req.ar.addr);
      end
      check_output("aw_valid", mst_req.aw_valid, slv_req.aw_valid && aw_can);
      check_output("aw_ready", slv_resp.aw_ready, mst_resp.aw_ready && aw_can);
      if (slv_req.aw_valid && aw_can) begin
        check_output("aw_id", mst_req.aw.id, aw_i);
        check_output("aw_len", mst_req.aw.len, slv_req.aw.len);
        check_output("aw_atop", mst_req.aw.atop, slv_req.aw.atop);
      end
      check_output("w_valid", mst_req.w_valid, slv_req.w_valid);
      if (slv_req.w_valid) check_output("w_data", mst_req.w.data, slv_req.w.data);
      check_output("r_valid", slv_resp.r_valid, mst_resp.r_valid);
      if (mst_resp.r_valid) begin
        check_output("r_data", slv_resp.r.data, mst_resp.r.data);
        if (mst_resp.r.id < Entries && m_cnt[0][mst_resp.r.id] > 0)
          check_output("r_id", slv_resp.r.id, m_id[0][mst_resp.r.id]);
      end
      check_output("b_valid", slv_resp.b_valid, mst_resp.b_valid);
      if (mst_resp.b_valid && mst_resp.b.id < Entries && m_cnt[1][mst_resp.b.id] > 0)
        check_output("b_id", slv_resp.b.id, m_id[1][mst_resp.b.id]);

      p_ar = slv_req.ar_valid && ar_can && mst_resp.ar_ready;
      p_ar_i = ar_i; p_ar_id = slv_req.ar.id;
      p_aw = slv_req.aw_valid && aw_can && mst_resp.aw_ready;
      p_aw_i = aw_i; p_aw_id = slv_req.aw.id; p_atop = slv_req.aw.atop[5];
      p_r = mst_resp.r_valid && slv_req.r_ready && mst_resp.r.last;
      p_r_i = int'(mst_resp.r.id);
      p_b = mst_resp.b_valid && slv_req.b_ready;
      p_b_i = int'(mst_resp.b.id);
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      if (p_ar) mdl_inc(0, p_ar_i, p_ar_id);
      if (p_aw) begin
        mdl_inc(1, p_aw_i, p_aw_id);
        if (p_atop) mdl_inc(0, p_aw_i, p_aw_id);
      end
      if (p_r) mdl_dec(0, p_r_i);
      if (p_b) mdl_dec(1, p_b_i);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ar_xfer(input logic [5:0] id, input logic [3:0] exp_mst, input string name);
    int c = 0;
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = id;
    slv_req.ar.addr  = 32'h1000_0000 | 32'(id);
    #2;
    while (!slv_resp.ar_ready && c < 50) begin
      @(posedge clk); #3; c++;
    end
    if (!slv_resp.ar_ready) timeout_fail(name);
    else check_output(name, mst_req.ar.id, exp_mst);
    step();
    slv_req.ar_valid = 1'b0;
  endtask

  task automatic aw_xfer(input logic [5:0] id, input logic [7:0] len, input logic [3:0] exp_mst, input string name);
    int c = 0;
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = id;
    slv_req.aw.len   = len;
    slv_req.aw.addr  = 32'h2000_0000 | 32'(id);
    slv_req.aw.atop  = 6'b000000;
    #2;
    while (!slv_resp.aw_ready && c < 50) begin
      @(posedge clk); #3; c++;
    end
    if (!slv_resp.aw_ready) timeout_fail(name);
    else check_output(name, mst_req.aw.id, exp_mst);
    step();
    slv_req.aw_valid = 1'b0;
  endtask

  task automatic set_r(input logic [3:0] mst_id, input logic last);
    mst_resp.r_valid = 1'b1;
    mst_resp.r.id    = mst_id;
    mst_resp.r.last  = last;
    mst_resp.r.data  = 32'hA5A5_0000 | 32'(mst_id);
  endtask

  task automatic r_beat(input logic [3:0] mst_id, input logic [5:0] exp_id, input string name);
    set_r(mst_id, 1'b1);
    #2;
    check_output(name, slv_resp.r.id, exp_id);
    step();
    mst_resp.r_valid = 1'b0;
  endtask

  task automatic b_beat(input logic [3:0] mst_id, input logic [5:0] exp_id, input string name);
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = mst_id;
    #2;
    check_output(name, slv_resp.b.id, exp_id);
    step();
    mst_resp.b_valid = 1'b0;
  endtask

  task automatic apply_stimulus();
    // Single read round trip; entry 0 must be free again afterwards.
    ar_xfer(6'h25, 4'd0, "single_ar_id");
    r_beat(4'd0, 6'h25, "single_r_id");
    ar_xfer(6'h30, 4'd0, "single_entry_freed");
    r_beat(4'd0, 6'h30, "single_r2_id");

    // Same ID four times fills one entry; the fifth waits for a last beat.
    for (int k = 0; k < 4; k++) ar_xfer(6'h13, 4'd0, "same_id_ar");
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 6'h13;
    #2;
    check_output("sat_stall_ready", slv_resp.ar_ready, 1'b0);
    check_output("sat_stall_valid", mst_req.ar_valid, 1'b0);
    step();
    set_r(4'd0, 1'b1);
    #2;
    check_output("sat_still_stalled", slv_resp.ar_ready, 1'b0);
    step();
    mst_resp.r_valid = 1'b0;
    #2;
    check_output("sat_released", slv_resp.ar_ready, 1'b1);
    step();
    slv_req.ar_valid = 1'b0;
    for (int k = 0; k < 4; k++) r_beat(4'd0, 6'h13, "sat_drain_id");

    // Hit and last beat on the same entry in one cycle leave it occupied.
    ar_xfer(6'h40, 4'd0, "incdec_first");
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 6'h40;
    set_r(4'd0, 1'b1);
    #2;
    check_output("incdec_ready", slv_resp.ar_ready, 1'b1);
    step();
    slv_req.ar_valid = 1'b0; mst_resp.r_valid = 1'b0;
    ar_xfer(6'h41, 4'd1, "incdec_not_freed");
    r_beat(4'd0, 6'h40, "incdec_r0");
    r_beat(4'd1, 6'h41, "incdec_r1");

    // Full table; a freed slot is only offered the cycle after its last beat.
    ar_xfer(6'h01, 4'd0, "full_ar0");
    ar_xfer(6'h02, 4'd1, "full_ar1");
    ar_xfer(6'h03, 4'd2, "full_ar2");
    ar_xfer(6'h04, 4'd3, "full_ar3");
    slv_req.ar_valid = 1'b1; slv_req.ar.id = 6'h05;
    #2;
    check_output("full_stall", slv_resp.ar_ready, 1'b0);
    step();
    set_r(4'd2, 1'b1);
    #2;
    check_output("full_r2_id", slv_resp.r.id, 6'h03);
    check_output("full_same_cycle", slv_resp.ar_ready, 1'b0);
    step();
    mst_resp.r_valid = 1'b0;
    #2;
    check_output("full_realloc_ready", slv_resp.ar_ready, 1'b1);
    check_output("full_realloc_id", mst_req.ar.id, 4'd2);
    step();
    slv_req.ar_valid = 1'b0;
    r_beat(4'd0, 6'h01, "full_drain0");
    r_beat(4'd1, 6'h02, "full_drain1");
    r_beat(4'd2, 6'h05, "full_drain2");
    r_beat(4'd3, 6'h04, "full_drain3");

    // Write burst with W beats passing straight through.
    aw_xfer(6'h3A, 8'd3, 4'd0, "wr_aw_id");
    for (int k = 0; k < 4; k++) begin
      slv_req.w_valid = 1'b1;
      slv_req.w.data  = 32'hC0DE_0000 + 32'(k);
      slv_req.w.strb  = 4'hF;
      slv_req.w.last  = (k == 3);
      #2;
      check_output("wr_w_data", mst_req.w.data, 32'hC0DE_0000 + 32'(k));
      step();
    end
    slv_req.w_valid = 1'b0; slv_req.w.last = 1'b0;
    b_beat(4'd0, 6'h3A, "wr_b_id");

    // R-returning ATOP waits for its read entry to drain, then owns both tables.
    ar_xfer(6'h22, 4'd0, "atop_pre_ar");
    slv_req.aw_valid = 1'b1; slv_req.aw.id = 6'h11;
    slv_req.aw.atop  = 6'b100000; slv_req.aw.len = 8'd0;
    #2;
    check_output("atop_stall", slv_resp.aw_ready, 1'b0);
    step();
    set_r(4'd0, 1'b1);
    #2;
    check_output("atop_pre_r_id", slv_resp.r.id, 6'h22);
    check_output("atop_still_stalled", slv_resp.aw_ready, 1'b0);
    step();
    mst_resp.r_valid = 1'b0;
    #2;
    check_output("atop_accept", slv_resp.aw_ready, 1'b1);
    check_output("atop_aw_id", mst_req.aw.id, 4'd0);
    step();
    slv_req.aw_valid = 1'b0; slv_req.aw.atop = 6'b000000;
    b_beat(4'd0, 6'h11, "atop_b_id");
    r_beat(4'd0, 6'h11, "atop_r_id");

    // Asynchronous reset with reads outstanding discards them.
    ar_xfer(6'h08, 4'd0, "rst_pre0");
    ar_xfer(6'h09, 4'd1, "rst_pre1");
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst_mid_ar_valid", mst_req.ar_valid, 1'b0);
    check_output("rst_mid_ar_ready", slv_resp.ar_ready, 1'b1);
    #10;
    rst_n = 1'b1;
    step();
    ar_xfer(6'h07, 4'd0, "rst_new_ar_id");
    r_beat(4'd0, 6'h07, "rst_new_r_id");
  endtask

  initial begin
    slv_req  = '0;
    mst_resp = '0;
    slv_req.r_ready    = 1'b1;
    slv_req.b_ready    = 1'b1;
    mst_resp.ar_ready  = 1'b1;
    mst_resp.aw_ready  = 1'b1;
    mst_resp.w_ready   = 1'b1;
    rst_n = 1'b0;
    #3;
    check_output("reset_ar_valid", mst_req.ar_valid, 1'b0);
    check_output("reset_ar_ready", slv_resp.ar_ready, 1'b1);
    check_output("reset_aw_ready", slv_resp.aw_ready, 1'b1);
    #9;
    rst_n = 1'b1;
    step();
    apply_stimulus();
    repeat (3) step();
    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/axi_id_compressor.md
Name: axi_id_compressor

Overview:
- Parametrised successor to the fixed 4-master SoC slave-side AXI typedefs: takes slave-side IDs widened by an N-master crossbar (IdWidth + $clog2(NoMstPorts) bits) and compresses them back onto a small pool of narrow master-side IDs.
- Sits between crossbar slave port and a narrow-ID peripheral/memory controller.
- Keeps per-direction remap tables with outstanding-transaction counters, restores original IDs on R/B, and preserves AXI per-ID ordering.

Parameters:
- NoMstPorts, 4, crossbar master count; SlvIdWidth = IdWidth + $clog2(NoMstPorts)
- IdWidth, 4, upstream master ID width (ariane_axi::IdWidth)
- MstIdWidth, 4, downstream ID width; must satisfy 2**MstIdWidth >= MaxUniqIds
- MaxUniqIds, 4, table entries per direction (distinct in-flight slave IDs)
- MaxTxnsPerId, 4, max outstanding transactions per entry; counter width $clog2(MaxTxnsPerId+1)
- slv_req_t / slv_resp_t, type, wide-ID request/response structs
- mst_req_t / mst_resp_t, type, narrow-ID request/response structs

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- slv_req_i  in  slv_req_t  wide-ID AXI request from crossbar
- slv_resp_o  out  slv_resp_t  wide-ID AXI response to crossbar
- mst_req_o  out  mst_req_t  narrow-ID AXI request to downstream
- mst_resp_i  in  mst_resp_t  narrow-ID AXI response from downstream

Behaviour:
- Two independent table instances: read (AR/R) and write (AW/B). Entry = {slv_id[SlvIdWidth-1:0], cnt}; entry free iff cnt==0.
- Lookup (combinational): hit = entry with cnt>0 and slv_id == request id (at most one hit by construction). Miss → allocate lowest-index free entry.
- can_accept = (hit && cnt<MaxTxnsPerId) || (!hit && free entry exists). Hit at saturated counter stalls; never allocates a second entry for same ID (ordering).
- AR: mst ar_valid = slv ar_valid & can_accept; mst ar.id = entry index zero-extended to MstIdWidth; all other fields pass through unchanged; slv ar_ready = mst ar_ready & can_accept. Valid never depends on ready.
- Entry write on mst AR handshake: on allocation store slv_id, cnt←1; on hit cnt←cnt+1.
- R: slv r.id = rd_table[mst r.id].slv_id; data/resp/last/user and valid/ready pass through; cnt decrements on R handshake with last=1.
- AW/B: identical to AR/R on write table; decrement on B handshake. W passes through unchanged (no ID).
- ATOP with atop[5]=1 (response on R): additionally requires read-table entry at the chosen write index to be free (or hit with same slv_id and cnt<MaxTxnsPerId); else AW stalls. On AW handshake that read entry is allocated/incremented with the same slv_id.
- Simultaneous increment and decrement on same entry in one cycle: cnt unchanged; entry does not free.
- Decrement to 0 and new allocation in same cycle: freed entry becomes allocatable next cycle only.
- Response with ID of a free entry: protocol error; assertion fires, slv id output undefined.
- No added latency: all channels combinational pass-through; only table state is registered.
- Reset (async, any time): all cnt←0, slv_id←0; outputs then follow inputs combinationally (valids low while inputs low). Transactions in flight at reset are discarded.

Decomposition:
- Shared package axi_id_compressor_pkg: cnt width function, table entry struct template constants. Typedefs for wide slave structs derived in ariane_axi_soc-style package from NoMstPorts.
- One sub-module: axi_id_compressor_table (lookup, allocate, count, free), instantiated twice.

Test Plan:
- Single read: AR id=0x25 → mst ar.id=0, R id=0 last → slv r.id=0x25, rd entry 0 cnt back to 0.
- Same ID x4 then 5th: four AR id=0x13 accepted on entry 0 (cnt=4); 5th stalls ar_ready=0 until one R last, then accepted next cycle.
- Table full: AR ids 0x01,0x02,0x03,0x04 → mst ids 0..3; AR id 0x05 stalls; R last on mst id 2 → 0x05 allocated to index 2 a cycle later.
- Write path with W: AW id=0x3A len=3 → mst aw.id=0, 4 W beats unchanged, B id=0 → slv b.id=0x3A.
- ATOP: AW atop=6'b100000 id=0x11 with read entry 0 busy on 0x22 → stall; after 0x22 R last, accepted; both B and R return id 0x11.
- Reset mid-flight: two ARs outstanding, pulse rst_ni low asynchronously → all counts 0; new AR id=0x07 maps to mst id 0.
